// File: rtl/uart_tx_monitor.sv
// Passive UART receiver that watches the SoC TX line and buffers decoded bytes
// in a small circular FIFO with framing-error pulse and sticky overflow flag.
module uart_tx_monitor #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_line,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          overflow
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        r_state, r_state_next;
  logic          r_sync1, r_sync2;
  logic [1:0]    r_sync_vld;
  logic          r_armed;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_ferr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_fall, w_tick, w_push, w_ferr, w_full, w_empty, w_pop, w_wr_en;

  // r_sync_vld marks when r_sync2 holds a real line sample rather than the
  // forced reset value, so a line held low at release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_sync1    <= uart_line;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_armed    <= r_sync_vld[1] & r_sync2;
    end
  end

  assign w_fall = r_sync_vld[1] & r_armed & ~r_sync2;
  assign w_tick = (r_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    w_push       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE:  if (w_fall) r_state_next = S_START;
      S_START: if (w_tick) r_state_next = r_sync2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && r_bit_cnt == 3'd7) r_state_next = S_STOP;
      S_STOP: begin
        if (w_tick) begin
          if (r_sync2) begin
            w_push       = 1'b1;
            r_state_next = S_IDLE;
          end else begin
            w_ferr       = 1'b1;
            r_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: if (r_sync2) r_state_next = S_IDLE;
      default: r_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 16'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_ferr    <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_cnt     <= HALF_M1;
            r_bit_cnt <= 3'd0;
          end
        end
        S_START, S_STOP: r_cnt <= w_tick ? FULL_M1 : r_cnt - 16'd1;
        S_DATA: begin
          if (w_tick) begin
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_cnt     <= FULL_M1;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'd0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign out_data      = r_mem[r_rd_ptr];
  assign out_valid     = ~w_empty;
  assign fifo_count    = r_count;
  assign framing_error = r_ferr;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Directed bench for uart_tx_monitor: serial frames in, scoreboard queue of
// expected bytes drained and compared against the FIFO output.
module tb_uart_tx_monitor;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_line = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic       framing_error;
  logic       overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ferr_pulses = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic model_ovf = 1'b0;
  logic [7:0] sb [$];

  uart_tx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_line    (uart_line),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .framing_error(framing_error),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (framing_error === 1'b1) ferr_pulses++;
    if (out_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = out_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_period(input logic v);
    uart_line = v;
    idle(CPB);
  endtask

  task automatic model_push(input logic [7:0] d);
    if (sb.size() < DEPTH) sb.push_back(d);
    else                   model_ovf = 1'b1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; the line is left at
  // the stop-bit level. With pop_at_stop, out_ready is raised for exactly the
  // cycle in which the stop bit is sampled.
  task automatic send(input logic [7:0] d, input logic stop_bit, input logic pop_at_stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
    uart_line = stop_bit;
    if (pop_at_stop) begin
      idle(6);
      chk("stop_pop_data", out_data, sb.pop_front());
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      idle(1);
    end else begin
      idle(CPB);
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, fifo_count, sb.size());
    while (sb.size() > 0) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, sb.pop_front());
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
    end
    chk({tag, "_empty_valid"}, out_valid, 0);
    chk({tag, "_empty_count"}, fifo_count, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    sb.delete();
    model_ovf = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_ferr"}, framing_error, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int c0;
    int f0;

    idle(2);
    chk_reset_outputs("reset");
    reset = 1'b0;
    idle(5);

    // Valid frame 0xA5, consumer stalled.
    c0 = cyc; rise_cyc = -1; f0 = ferr_pulses;
    send(8'hA5, 1'b1, 1'b0);
    model_push(8'hA5);
    uart_line = 1'b1;
    chk("a5_rise_latency", rise_cyc - c0, 79);
    chk("a5_count", fifo_count, 1);
    idle(5);
    chk("a5_stable_data", out_data, 8'hA5);
    chk("a5_no_ferr", ferr_pulses - f0, 0);
    drain("a5");

    // Short low glitch from idle.
    f0 = ferr_pulses;
    uart_line = 1'b0; idle(3);
    uart_line = 1'b1; idle(30);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_valid", out_valid, 0);
    chk("glitch_ferr", ferr_pulses - f0, 0);

    // Bad stop bit, long break, then a good frame.
    f0 = ferr_pulses;
    send(8'h3C, 1'b0, 1'b0);
    uart_line = 1'b0; idle(40);
    uart_line = 1'b1; idle(10);
    send(8'h81, 1'b1, 1'b0);
    model_push(8'h81);
    uart_line = 1'b1; idle(4);
    chk("break_ferr_pulses", ferr_pulses - f0, 1);
    drain("break");

    // Five back-to-back frames into a 4-deep FIFO.
    for (int d = 1; d <= 5; d++) begin
      send(8'(d), 1'b1, 1'b0);
      model_push(8'(d));
    end
    uart_line = 1'b1; idle(4);
    chk("ovf_flag", overflow, model_ovf);
    chk("ovf_count", fifo_count, DEPTH);
    drain("ovf");
    chk("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    idle(5);
    for (int d = 1; d <= 4; d++) begin
      send(8'(8'h11 * d), 1'b1, 1'b0);
      model_push(8'(8'h11 * d));
    end
    chk("full_count", fifo_count, DEPTH);
    send(8'h55, 1'b1, 1'b1);
    model_push(8'h55);
    uart_line = 1'b1; idle(2);
    chk("pushpop_count", fifo_count, DEPTH);
    chk("pushpop_ovf", overflow, model_ovf);
    drain("pushpop");

    // Line held low across reset release must not start a frame.
    f0 = ferr_pulses;
    uart_line = 1'b0;
    do_reset();
    idle(30);
    uart_line = 1'b1; idle(100);
    chk("lowrel_count", fifo_count, 0);
    chk("lowrel_ferr", ferr_pulses - f0, 0);

    // Reset during data bit 4 of 0xF0 with a byte already buffered.
    send(8'h77, 1'b1, 1'b0);
    model_push(8'h77);
    uart_line = 1'b1; idle(4);
    chk("pre_mid_count", fifo_count, 1);
    f0 = ferr_pulses;
    bit_period(1'b0);
    for (int i = 0; i < 4; i++) bit_period(1'b0);
    uart_line = 1'b1; idle(4);
    reset = 1'b1;
    idle(1);
    chk_reset_outputs("mid_reset");
    idle(1);
    reset = 1'b0;
    sb.delete();
    model_ovf = 1'b0;
    idle(40);
    chk("mid_after_count", fifo_count, 0);
    chk("mid_after_ferr", ferr_pulses - f0, 0);
    send(8'h12, 1'b1, 1'b0);
    model_push(8'h12);
    uart_line = 1'b1; idle(4);
    drain("mid_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_monitor.md
UART_TX_MONITOR -- requirements
Module: uart_tx_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: received-byte buffer entries; power of two, 2..16.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock (same clock as the SoC main clock).
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port uart_line, input, 1 bit: SoC io_uart_txd, asynchronous, idle high.
REQ-007 SHALL have port out_data, output, 8 bits: head-of-FIFO byte.
REQ-008 SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the head byte.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-011 SHALL have port framing_error, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.

Function
REQ-013 SHALL pass uart_line through a 2-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: a synchronized 1->0 transition SHALL load the bit counter and enter START.
REQ-016 START: at CLKS_PER_BIT/2 (integer division) cycles after the edge, SHALL sample the line; 0 -> DATA; 1 -> IDLE (glitch, nothing reported).
REQ-017 DATA: SHALL sample every CLKS_PER_BIT cycles from the start-bit centre, 8 bits, LSB first, into a shift register.
REQ-018 STOP: SHALL sample CLKS_PER_BIT cycles after bit 7.
REQ-019 Stop sample 1: SHALL push the byte and return to IDLE in the same cycle.
REQ-020 Stop sample 0: SHALL discard the byte, pulse framing_error for exactly 1 cycle, and enter BREAK.
REQ-021 BREAK: SHALL stay until the synchronized line reads 1, then go to IDLE; no start detection while in BREAK.
REQ-022 A pushed byte SHALL appear with out_valid=1 on the cycle after the stop sample.
REQ-023 out_valid && out_ready SHALL pop exactly one entry per cycle.
REQ-024 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 FIFO SHALL be a circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 Push while full with no pop SHALL drop the new byte, keep FIFO contents, and set overflow.
REQ-027 Push and pop in the same cycle while full SHALL both occur; count unchanged; overflow not set.
REQ-028 Push and pop in the same cycle while non-empty and not full SHALL leave the count unchanged.
REQ-029 overflow SHALL remain 1 until reset.
REQ-030 fifo_count SHALL equal pushes minus pops since reset, within 0..FIFO_DEPTH.

Reset
REQ-031 On reset SHALL set: state IDLE; synchronizer flops 1; counters 0; pointers 0; out_valid 0; fifo_count 0; framing_error 0; overflow 0; out_data 0.
REQ-032 Reset mid-frame SHALL abandon the frame, report nothing, and require a fresh 1->0 edge after release.
REQ-033 A line held low at reset release SHALL NOT start a frame until it returns high and falls again.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-034 Send 0xA5 with a valid stop bit, out_ready=0 -> out_valid rises 1 cycle after the stop sample; out_data=0xA5; fifo_count=1; framing_error never 1.
REQ-035 Drive a 3-cycle low glitch from idle -> return to IDLE; fifo_count stays 0; no pulses.
REQ-036 Send 0x3C with stop bit=0, then hold the line low 40 cycles, then high, then send 0x81 -> one framing_error pulse; only 0x81 enters the FIFO.
REQ-037 Send 0x01..0x05 back-to-back, out_ready=0 -> FIFO holds 0x01..0x04; overflow=1; fifo_count=4; pops return 0x01, 0x02, 0x03, 0x04 in order.
REQ-038 Fill the FIFO, then hold out_ready=1 while 0x55 completes -> push and pop in the same cycle; fifo_count stays 4; overflow=0; 0x55 is the last byte read.
REQ-039 Assert reset during DATA bit 4 of 0xF0 -> all outputs reach reset values; no byte is reported; the next complete frame 0x12 is received correctly.
